// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle for the multicycle MIPS main controller.
// master = controller (drives enables/selects), slave = datapath + memory side.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       error;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst,
           mem_to_reg, error, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst,
           mem_to_reg, error, state
  );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM with a memory-wait watchdog.
// Optional: define BNE_EN to decode op 000101 into the BNE branch state.
module mc_main_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11,
    S_BNE    = 4'd12,
    S_ERROR  = 4'd15
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             in_wait;
  logic             wait_hit;
  logic [2:0]       rex_alu;
  logic             rex_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // R-type function decode; unknown funct falls back to ADD and flags a fault
  always_comb begin
    rex_alu = ALU_ADD;
    rex_ok  = 1'b1;
    case (bus.funct)
      6'b100100: rex_alu = ALU_AND;
      6'b100101: rex_alu = ALU_OR;
      6'b100000: rex_alu = ALU_ADD;
      6'b100111: rex_alu = ALU_NOR;
      6'b100010: rex_alu = ALU_SUB;
      6'b000000: rex_alu = ALU_SLL;
      6'b000010: rex_alu = ALU_SRL;
      6'b101010: rex_alu = ALU_SLT;
      default:   rex_ok  = 1'b0;
    endcase
  end

  // Watchdog: the MEM_WAIT_MAX-th consecutive stalled cycle forces ERROR; mem_ready wins
  assign in_wait  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign wait_hit = (wait_q == CNT_W'(MEM_WAIT_MAX - 1));
  assign wait_d   = (in_wait && !bus.mem_ready && !wait_hit) ? wait_q + CNT_W'(1) : '0;

  assign bus.state = state_q;

  // Next state and Moore outputs; everything is held inactive while reset is asserted
  always_comb begin
    state_d        = state_q;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_ctrl   = ALU_AND;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.error      = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.alu_ctrl  = ALU_ADD;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = S_DECODE;
          end else if (wait_hit) begin
            state_d = S_ERROR;
          end
        end
        S_DECODE: begin
          bus.alu_src_b = 2'b11;
          bus.alu_ctrl  = ALU_ADD;
          case (bus.op)
            OP_RTYPE:     state_d = S_REX;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BEQ;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JEX;
`ifdef BNE_EN
            OP_BNE:       state_d = S_BNE;
`endif
            default:      state_d = S_ERROR;
          endcase
        end
        S_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_ctrl  = ALU_ADD;
          if (bus.op == OP_LW)      state_d = S_MEMRD;
          else if (bus.op == OP_SW) state_d = S_MEMWR;
          else                      state_d = S_ERROR;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
          if (bus.mem_ready) state_d = S_MEMWB;
          else if (wait_hit) state_d = S_ERROR;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          state_d        = S_FETCH;
        end
        S_MEMWR: begin
          bus.mem_req   = 1'b1;
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
          if (bus.mem_ready) state_d = S_FETCH;
          else if (wait_hit) state_d = S_ERROR;
        end
        S_REX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = rex_alu;
          state_d       = rex_ok ? S_RWB : S_ERROR;
        end
        S_RWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
          state_d       = S_FETCH;
        end
        S_BEQ: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = ALU_SUB;
          bus.pc_src    = 2'b01;
          bus.pc_write  = bus.zero;
          state_d       = S_FETCH;
        end
`ifdef BNE_EN
        S_BNE: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = ALU_SUB;
          bus.pc_src    = 2'b01;
          bus.pc_write  = ~bus.zero;
          state_d       = S_FETCH;
        end
`endif
        S_ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_ctrl  = ALU_ADD;
          state_d       = S_ADDIWB;
        end
        S_ADDIWB: begin
          bus.reg_write = 1'b1;
          state_d       = S_FETCH;
        end
        S_JEX: begin
          bus.pc_src   = 2'b10;
          bus.pc_write = 1'b1;
          state_d      = S_FETCH;
        end
        S_ERROR: begin
          bus.error = 1'b1;
        end
        default: state_d = S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: directed scenarios then random instruction streams,
// each instruction expanded into its expected per-cycle state/output trace.
module tb_mc_main_ctrl;

  localparam int MEM_WAIT_MAX = 16;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_REX = 4'd6, S_RWB = 4'd7,
                         S_BEQ = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JEX = 4'd11,
                         S_BNE = 4'd12, S_ERROR = 4'd15;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_J = 6'b000010, OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_BAD = 6'b111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       error;
    logic [3:0] state;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] cur_funct = 6'd0;
  int         checks = 0;
  int         failures = 0;

  mc_ctrl_if bus ();

  mc_main_ctrl #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic outs_t obs();
    outs_t o;
    o.mem_req = bus.mem_req;     o.mem_write = bus.mem_write;   o.iord = bus.iord;
    o.ir_write = bus.ir_write;   o.pc_write = bus.pc_write;     o.pc_src = bus.pc_src;
    o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b;   o.alu_ctrl = bus.alu_ctrl;
    o.reg_write = bus.reg_write; o.reg_dst = bus.reg_dst;       o.mem_to_reg = bus.mem_to_reg;
    o.error = bus.error;         o.state = bus.state;
    return o;
  endfunction

  // R-type funct -> ALU operation; {known, op}
  function automatic logic [3:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b100000: return 4'b1_010;
      6'b100111: return 4'b1_011;
      6'b100010: return 4'b1_110;
      6'b000000: return 4'b1_100;
      6'b000010: return 4'b1_101;
      6'b101010: return 4'b1_111;
      default:   return 4'b0_010;
    endcase
  endfunction

  function automatic outs_t exp_of(input logic [3:0] st, input logic mr, input logic z,
                                   input logic [5:0] fn);
    outs_t      e;
    logic [3:0] fa;
    e = '0;
    e.state = st;
    fa = funct_alu(fn);
    case (st)
      S_FETCH:  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_ctrl = 3'b010;
                      e.ir_write = mr; e.pc_write = mr; end
      S_DECODE: begin e.alu_src_b = 2'b11; e.alu_ctrl = 3'b010; end
      S_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010; end
      S_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
      S_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      S_MEMWR:  begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; end
      S_REX:    begin e.alu_src_a = 1; e.alu_ctrl = fa[2:0]; end
      S_RWB:    begin e.reg_write = 1; e.reg_dst = 1; end
      S_BEQ:    begin e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01; e.pc_write = z; end
      S_BNE:    begin e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01; e.pc_write = ~z; end
      S_ADDIEX: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010; end
      S_ADDIWB: begin e.reg_write = 1; end
      S_JEX:    begin e.pc_src = 2'b10; e.pc_write = 1; end
      S_ERROR:  begin e.error = 1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check settled outputs 1 time unit later
  task automatic step(input logic [3:0] st, input logic mr, input logic z, input string tag);
    outs_t e, o;
    bus.mem_ready = mr;
    bus.zero = z;
    #1;
    e = exp_of(st, mr, z, cur_funct);
    o = obs();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
    @(negedge clk);
  endtask

  task automatic reset_dut(input string tag);
    outs_t o;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    #1;
    o = obs();
    checks++;
    assert (o === outs_t'(0)) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, outs_t'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic error_phase(input string tag);
    for (int i = 0; i < 3; i++) step(S_ERROR, rb(), rb(), tag);
    reset_dut({tag, "_reset"});
  endtask

  // w stalled cycles, then completion; a full MEM_WAIT_MAX stall means timeout
  task automatic mem_phase(input logic [3:0] st, input int w, input string tag, output bit err);
    err = 1'b0;
    for (int i = 0; i < w && i < MEM_WAIT_MAX; i++) step(st, 1'b0, rb(), tag);
    if (w >= MEM_WAIT_MAX) err = 1'b1;
    else step(st, 1'b1, rb(), tag);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input logic z);
    bit         err;
    logic [3:0] fa;
    bus.op = op;
    bus.funct = fn;
    cur_funct = fn;
    fa = funct_alu(fn);
    mem_phase(S_FETCH, fw, "fetch", err);
    if (err) begin
      error_phase("fetch_timeout");
      return;
    end
    step(S_DECODE, rb(), rb(), "decode");
    case (op)
      OP_R: begin
        step(S_REX, rb(), rb(), "rex");
        if (fa[3]) step(S_RWB, rb(), rb(), "rwb");
        else error_phase("bad_funct");
      end
      OP_LW: begin
        step(S_MEMADR, rb(), rb(), "lw_adr");
        mem_phase(S_MEMRD, mw, "memrd", err);
        if (err) error_phase("memrd_timeout");
        else step(S_MEMWB, rb(), rb(), "memwb");
      end
      OP_SW: begin
        step(S_MEMADR, rb(), rb(), "sw_adr");
        mem_phase(S_MEMWR, mw, "memwr", err);
        if (err) error_phase("memwr_timeout");
      end
      OP_BEQ:  step(S_BEQ, rb(), z, "beq");
`ifdef BNE_EN
      OP_BNE:  step(S_BNE, rb(), z, "bne");
`endif
      OP_ADDI: begin
        step(S_ADDIEX, rb(), rb(), "addiex");
        step(S_ADDIWB, rb(), rb(), "addiwb");
      end
      OP_J:    step(S_JEX, rb(), rb(), "jex");
      default: error_phase("bad_op");
    endcase
  endtask

  logic [5:0] op_pool [9];
  logic [5:0] fn_pool [9];
  bit         err_mid;

  initial begin
    op_pool = '{OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_BAD};
    fn_pool = '{6'b100100, 6'b100101, 6'b100000, 6'b100111, 6'b100010,
                6'b000000, 6'b000010, 6'b101010, F_BAD};
    bus.op = 6'd0;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    reset_dut("reset");

    // Directed scenarios
    run_instr(OP_R, F_ADD, 3, 0, 1'b0);
    run_instr(OP_R, F_ADD, 0, 0, 1'b0);
    run_instr(OP_LW, 6'd0, 0, 5, 1'b0);
    run_instr(OP_SW, 6'd0, 1, 2, 1'b0);
    run_instr(OP_BEQ, 6'd0, 0, 0, 1'b1);
    run_instr(OP_BEQ, 6'd0, 0, 0, 1'b0);
    run_instr(OP_J, 6'd0, MEM_WAIT_MAX - 1, 0, 1'b0);
    run_instr(OP_ADDI, 6'd0, 0, 0, 1'b0);
    run_instr(OP_R, F_ADD, MEM_WAIT_MAX, 0, 1'b0);
    run_instr(OP_BAD, 6'd0, 0, 0, 1'b0);
    run_instr(OP_R, F_BAD, 0, 0, 1'b0);
    run_instr(OP_BNE, 6'd0, 0, 0, 1'b0);
    run_instr(OP_BNE, 6'd0, 0, 0, 1'b1);
    run_instr(OP_LW, 6'd0, 0, MEM_WAIT_MAX - 1, 1'b0);
    run_instr(OP_SW, 6'd0, 0, MEM_WAIT_MAX, 1'b0);

    // Reset while a load is stalled in the read state
    bus.op = OP_LW;
    cur_funct = bus.funct;
    mem_phase(S_FETCH, 0, "mid_fetch", err_mid);
    step(S_DECODE, 1'b0, 1'b0, "mid_decode");
    step(S_MEMADR, 1'b0, 1'b0, "mid_adr");
    step(S_MEMRD, 1'b0, 1'b0, "mid_memrd");
    reset_dut("mid_reset");
    run_instr(OP_SW, 6'd0, 0, 0, 1'b0);

    // Random instruction stream
    for (int n = 0; n < 80; n++) begin
      int fw, mw;
      fw = ($urandom_range(19, 0) == 0) ? MEM_WAIT_MAX : int'($urandom_range(5, 0));
      mw = ($urandom_range(19, 0) == 0) ? MEM_WAIT_MAX : int'($urandom_range(7, 0));
      run_instr(op_pool[$urandom_range(8, 0)], fn_pool[$urandom_range(8, 0)], fw, mw, rb());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle MIPS main controller FSM; the issuing end of the ALU control interface.
- Decodes op/funct from the instruction register, sequences fetch/decode/execute/memory/writeback, drives datapath muxes and the 3-bit ALU ctrl, consumes the ALU zero flag.
- Handshakes with a variable-latency memory via mem_req/mem_ready, with a wait-timeout watchdog.

Parameters:
- MEM_WAIT_MAX, 16: max consecutive cycles a memory state waits for mem_ready before entering ERROR (min 1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  instruction[31:26], valid from DECODE onward
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag, same-cycle combinational
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  request is a write
- iord  out  1  0 = PC address, 1 = ALUOut address
- ir_write  out  1  load instruction register
- pc_write  out  1  PC enable (unconditional | branch&zero)
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_ctrl  out  3  000 AND, 001 OR, 010 ADD, 011 NOR, 110 SUB, 100 SLL, 101 SRL, 111 SLT
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- error  out  1  sticky fault flag
- state  out  4  current state encoding (debug)

Behaviour:
- Moore outputs decoded from registered state; pc_write additionally gated by zero in BEQ.
- Reset (rst_n low, asynchronous): state = FETCH (0), wait counter = 0, error = 0; all enables 0 while in reset.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, RWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JEX 11, ERROR 15.
- Unlisted outputs are 0 in each state.
- FETCH
  - Outputs: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_ctrl = ADD, pc_src = 00.
  - ir_write and pc_write assert only in the cycle mem_ready = 1; then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_ctrl = ADD (branch target precompute).
  - Next state by op: 000000 -> REX, 100011/101011 -> MEMADR, 000100 -> BEQ, 001000 -> ADDIEX, 000010 -> JEX, any other -> ERROR.
- MEMADR
  - Outputs: alu_src_a = 1, alu_src_b = 10, ADD.
  - Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req = 1, iord = 1; on mem_ready -> MEMWB.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1; -> FETCH.
- MEMWR: mem_req = 1, mem_write = 1, iord = 1; on mem_ready -> FETCH.
- REX
  - Outputs: alu_src_a = 1, alu_src_b = 00.
  - alu_ctrl from funct: 100100 AND, 100101 OR, 100000 ADD, 100111 NOR, 100010 SUB, 000000 SLL, 000010 SRL, 101010 SLT.
  - Next: RWB; unknown funct -> ERROR (alu_ctrl = ADD that cycle).
- RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0; -> FETCH.
- BEQ
  - Outputs: alu_src_a = 1, alu_src_b = 00, SUB, pc_src = 01.
  - pc_write = zero; -> FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, ADD; -> ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0; -> FETCH.
- JEX: pc_src = 10, pc_write = 1; -> FETCH.
- ERROR: error = 1, all enables 0; held until reset.
- Wait counter
  - Increments each cycle in FETCH/MEMRD/MEMWR with mem_ready = 0.
  - Clears on mem_ready or on leaving the state.
  - Reaching MEM_WAIT_MAX -> ERROR next cycle.
  - mem_ready in the same cycle the count hits the limit: completion wins.
- mem_ready outside memory states is ignored.
- rst_n asserted mid-instruction aborts immediately to FETCH; no partial writes issued after reset.

Optional Feature:
- BNE_EN
  - Defined: op 000101 decodes to BNE state (encoding 12), same outputs as BEQ but pc_write = ~zero.
  - Undefined: op 000101 -> ERROR.

Test Plan:
- Reset, then mem_ready = 1 at cycle 3 -> state 0 for cycles 0-2, ir_write = pc_write = 1 only at cycle 3, state = 1 at cycle 4.
- R-type add (op 000000, funct 100000), mem_ready immediate -> FETCH, DECODE, REX with alu_ctrl = 010, RWB with reg_write = 1 and reg_dst = 1, back to FETCH; 4 cycles total.
- lw with MEMRD mem_ready delayed 5 cycles -> MEMRD held 6 cycles, then MEMWB with mem_to_reg = 1; sw -> MEMWR with mem_write = 1, no reg_write.
- beq with zero = 1 then zero = 0 -> pc_write = 1 / 0 in BEQ, alu_ctrl = 110, pc_src = 01.
- mem_ready held 0 in FETCH with MEM_WAIT_MAX = 16 -> ERROR after 16 wait cycles, error = 1 sticky; rst_n pulse -> state 0, error 0.
- op 111111, or funct 111111 under R-type -> ERROR; op 000101 -> BNE branching on zero = 0 with BNE_EN, ERROR without.
